// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Pipeline hazard controller sitting beside the ID stage. Instead of comparing
// the ID sources against EX/MEM destinations, it keeps two countdowns per
// architectural register:
//   fwd_cnt[r] : cycles until the pending result for r can be forwarded
//                (nonzero only while a load is in flight)
//   wb_cnt[r]  : cycles until the pending result for r reaches the register
//                file (branch targets are read there, not forwarded)
// A saturating counter of bubble cycles is kept for performance debug.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   id_valid           : ID holds a real instruction
//   opcode             : ID opcode (BR_OP_MASK selects branch ops reading rb)
//   ra, rb             : ID source registers
//   ra_used, rb_used   : ID actually reads ra / rb
//   rd, rd_we          : ID destination register and its write enable
//   is_load            : ID instruction is a memory read
//   branch_take        : branch resolved taken in EX this cycle
//   pc_en, if_id_en    : advance PC / IF-ID register
//   bubble             : insert NOP into ID/EX
//   flush              : squash IF/ID contents
//   stall_cycles       : saturating count of bubble cycles

module hazard_scoreboard #(
    parameter int          REG_AW     = 2,
    parameter int          LOAD_LAT   = 1,
    parameter int          WB_LAT     = 2,
    parameter int          CNT_W      = 2,
    parameter logic [15:0] BR_OP_MASK = 16'h0E00,
    parameter int          PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic              ra_used,
    input  logic              rb_used,
    input  logic [REG_AW-1:0] rd,
    input  logic              rd_we,
    input  logic              is_load,
    input  logic              branch_take,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              bubble,
    output logic              flush,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int NREGS = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] WB_CNT   = CNT_W'(WB_LAT);

    logic [CNT_W-1:0] fwd_cnt [NREGS];
    logic [CNT_W-1:0] wb_cnt  [NREGS];

    logic is_br;
    logic load_use;
    logic br_hz;
    logic issue;

    // Hazard detection uses the counters as they stand before this edge, so a
    // write issued this cycle never blocks the instruction that issues it.
    always_comb begin
        is_br    = BR_OP_MASK[opcode];
        load_use = id_valid &
                   ((ra_used & (fwd_cnt[ra] != '0)) |
                    (rb_used & (fwd_cnt[rb] != '0)));
        br_hz    = id_valid & is_br & (wb_cnt[rb] != '0);
    end

    // Control outputs. A taken branch squashes ID, so any hazard the squashed
    // instruction would have raised is irrelevant and no bubble is inserted.
    // While reset is asserted the pipe runs freely with no flush.
    always_comb begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;
        if (!rst) begin
            if (branch_take) begin
                flush = 1'b1;
            end else if (load_use || br_hz) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                bubble   = 1'b1;
            end
        end
    end

    assign issue = id_valid & ~branch_take & ~bubble & ~rst;

    // Countdowns: everything ticks toward zero; a newly issued writer reloads
    // its destination, overriding the tick so the newest writer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                fwd_cnt[i] <= '0;
                wb_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (issue && rd_we && (rd == i[REG_AW-1:0])) begin
                    fwd_cnt[i] <= is_load ? LOAD_CNT : '0;
                    wb_cnt[i]  <= WB_CNT;
                end else begin
                    if (fwd_cnt[i] != '0) fwd_cnt[i] <= fwd_cnt[i] - 1'b1;
                    if (wb_cnt[i]  != '0) wb_cnt[i]  <= wb_cnt[i]  - 1'b1;
                end
            end
        end
    end

    // Bubble-cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (bubble && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
